// File: rtl/parity_scan_ctrl.sv
// parity_scan_ctrl
// Walks an address range [lo_addr..hi_addr] (mod 16, wrapping through 15->0)
// over the two-bank fetch path, waits RD_LAT cycles per address, then checks
// the stored parity bit against bit 0 of the fetched byte. Reports a
// saturating mismatch count and the address of the first failing word.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start, abort        scan request (IDLE only) / terminate scan (non-IDLE)
//   lo_addr, hi_addr    range bounds, latched on an accepted start
//   mem_addr            registered fetch address, bit 3 selects the bank
//   mem_data, mem_parity fetched byte and its stored parity bit
//   busy, done          scan in progress / one-cycle completion pulse
//   err_count           mismatch count of current or last scan, saturating
//   first_err_valid/addr first mismatching address capture
//
// state  | meaning
// IDLE   | waiting for start; status registers hold last scan result
// WAIT   | read latency countdown for the current mem_addr
// CHECK  | compare mem_data[0] with mem_parity, advance or finish
// DONE   | one-cycle done pulse, then back to IDLE
module parity_scan_ctrl #(
  parameter int RD_LAT    = 1,
  parameter int ERR_CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           lo_addr,
  input  logic [3:0]           hi_addr,
  output logic [3:0]           mem_addr,
  input  logic [7:0]           mem_data,
  input  logic                 mem_parity,
  output logic                 busy,
  output logic                 done,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_valid,
  output logic [3:0]           first_err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [2:0]           WAIT_LOAD = 3'(RD_LAT - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  state_t                 state, state_nxt;
  logic [3:0]             addr_nxt;
  logic [3:0]             hi_q, hi_nxt;
  logic [2:0]             wait_cnt, wait_nxt;
  logic [ERR_CNT_W-1:0]   err_nxt;
  logic                   fv_nxt;
  logic [3:0]             fa_nxt;
  logic                   mismatch;

  // Only bit 0 of the fetched byte carries the parity-checked value.
  logic unused_data_bits;
  assign unused_data_bits = ^mem_data[7:1];

  assign mismatch = (mem_data[0] != mem_parity);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      mem_addr        <= 4'd0;
      hi_q            <= 4'd0;
      wait_cnt        <= 3'd0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= 4'd0;
    end else begin
      state           <= state_nxt;
      mem_addr        <= addr_nxt;
      hi_q            <= hi_nxt;
      wait_cnt        <= wait_nxt;
      err_count       <= err_nxt;
      first_err_valid <= fv_nxt;
      first_err_addr  <= fa_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    hi_nxt    = hi_q;
    wait_nxt  = wait_cnt;
    err_nxt   = err_count;
    fv_nxt    = first_err_valid;
    fa_nxt    = first_err_addr;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        // abort in the same cycle as start cancels the request
        if (start && !abort) begin
          state_nxt = S_WAIT;
          hi_nxt    = hi_addr;
          addr_nxt  = lo_addr;
          err_nxt   = '0;
          fv_nxt    = 1'b0;
          wait_nxt  = WAIT_LOAD;
        end
      end

      S_WAIT: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (wait_cnt == 3'd0) begin
          state_nxt = S_CHECK;
        end else begin
          wait_nxt = wait_cnt - 3'd1;
        end
      end

      S_CHECK: begin
        busy = 1'b1;
        // The check result is kept even when this cycle is aborted.
        if (mismatch) begin
          if (err_count != ERR_MAX) err_nxt = err_count + 1'b1;
          if (!first_err_valid) begin
            fv_nxt = 1'b1;
            fa_nxt = mem_addr;
          end
        end
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (mem_addr == hi_q) begin
          state_nxt = S_DONE;
        end else begin
          addr_nxt  = mem_addr + 4'd1;
          wait_nxt  = WAIT_LOAD;
          state_nxt = S_WAIT;
        end
      end

      S_DONE: begin
        done      = !abort;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_parity_scan_ctrl.sv
module tb_parity_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] start = 3'b000;
  logic       abort = 1'b0;
  logic [3:0] lo_addr = 4'd0;
  logic [3:0] hi_addr = 4'd0;

  logic [3:0]  mem_addr_o [3];
  logic [7:0]  mem_data_i [3];
  logic        mem_par_i  [3];
  logic        busy_o     [3];
  logic        done_o     [3];
  logic        fv_o       [3];
  logic [3:0]  fa_o       [3];
  logic [4:0]  err0, err1;
  logic [1:0]  err2;
  logic [4:0]  err_o      [3];
  logic [15:0] mask       [3];

  int checks = 0;
  int failures = 0;

  // d0: RD_LAT=1, d1: RD_LAT=2, d2: RD_LAT=1 with 2-bit error counter
  int lat  [3] = '{1, 2, 1};
  int satv [3] = '{31, 31, 3};

  always #5 clk = ~clk;

  parity_scan_ctrl #(.RD_LAT(1), .ERR_CNT_W(5)) u_d0 (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort),
    .lo_addr(lo_addr), .hi_addr(hi_addr), .mem_addr(mem_addr_o[0]),
    .mem_data(mem_data_i[0]), .mem_parity(mem_par_i[0]), .busy(busy_o[0]),
    .done(done_o[0]), .err_count(err0), .first_err_valid(fv_o[0]),
    .first_err_addr(fa_o[0]));

  parity_scan_ctrl #(.RD_LAT(2), .ERR_CNT_W(5)) u_d1 (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort),
    .lo_addr(lo_addr), .hi_addr(hi_addr), .mem_addr(mem_addr_o[1]),
    .mem_data(mem_data_i[1]), .mem_parity(mem_par_i[1]), .busy(busy_o[1]),
    .done(done_o[1]), .err_count(err1), .first_err_valid(fv_o[1]),
    .first_err_addr(fa_o[1]));

  parity_scan_ctrl #(.RD_LAT(1), .ERR_CNT_W(2)) u_d2 (
    .clk(clk), .reset(reset), .start(start[2]), .abort(abort),
    .lo_addr(lo_addr), .hi_addr(hi_addr), .mem_addr(mem_addr_o[2]),
    .mem_data(mem_data_i[2]), .mem_parity(mem_par_i[2]), .busy(busy_o[2]),
    .done(done_o[2]), .err_count(err2), .first_err_valid(fv_o[2]),
    .first_err_addr(fa_o[2]));

  assign err_o[0] = err0;
  assign err_o[1] = err1;
  assign err_o[2] = {3'b000, err2};

  // Combinational memory: parity is correct unless the mask marks the address.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mem_data_i[i] = {mem_addr_o[i], ~mem_addr_o[i]};
      mem_par_i[i]  = mem_data_i[i][0] ^ mask[i][mem_addr_o[i]];
    end
  end

  // ---------------- behavioural model ----------------
  // A scan is described by its start cycle count t, first address and word
  // count; outputs are derived arithmetically from t.
  bit         m_act  [3] = '{default: 1'b0};
  int         m_t    [3] = '{default: 0};
  int         m_lo   [3] = '{default: 0};
  int         m_n    [3] = '{default: 0};
  logic [3:0] m_addr [3] = '{default: 4'd0};
  int         m_err  [3] = '{default: 0};
  bit         m_fv   [3] = '{default: 1'b0};
  logic [3:0] m_fa   [3] = '{default: 4'd0};

  task automatic tally(input int i, input int completed, output int err,
                       output bit fv, output logic [3:0] fa);
    logic [3:0] a;
    err = 0; fv = 1'b0; fa = m_fa[i];
    for (int w = 0; w < completed; w++) begin
      a = 4'(m_lo[i] + w);
      if (mask[i][a]) begin
        if (!fv) begin fv = 1'b1; fa = a; end
        if (err < satv[i]) err++;
      end
    end
  endtask

  task automatic expect_now(input int i, output logic [3:0] ea, output bit eb,
                            output bit ed, output int ee, output bit efv,
                            output logic [3:0] efa);
    int len, total, comp;
    if (!m_act[i]) begin
      ea = m_addr[i]; eb = 1'b0; ed = 1'b0;
      ee = m_err[i]; efv = m_fv[i]; efa = m_fa[i];
    end else begin
      len   = lat[i] + 1;
      total = m_n[i] * len;
      if (m_t[i] < total) begin
        eb = 1'b1; ed = 1'b0; ea = 4'(m_lo[i] + m_t[i] / len);
      end else begin
        eb = 1'b0; ed = !abort; ea = 4'(m_lo[i] + m_n[i] - 1);
      end
      comp = m_t[i] / len;
      if (comp > m_n[i]) comp = m_n[i];
      tally(i, comp, ee, efv, efa);
    end
  endtask

  always @(posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_addr[i] = 4'd0; m_err[i] = 0;
      m_fv[i] = 1'b0; m_fa[i] = 4'd0;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        int len, total, comp, e;
        bit fv;
        logic [3:0] fa;
        if (!m_act[i]) begin
          if (start[i] && !abort) begin
            m_act[i] = 1'b1;
            m_t[i]   = 0;
            m_lo[i]  = int'(lo_addr);
            m_n[i]   = int'(4'(hi_addr - lo_addr)) + 1;
          end
        end else begin
          len   = lat[i] + 1;
          total = m_n[i] * len;
          if (abort || m_t[i] == total) begin
            comp = abort ? (m_t[i] + 1) / len : m_n[i];
            if (comp > m_n[i]) comp = m_n[i];
            tally(i, comp, e, fv, fa);
            m_err[i] = e; m_fv[i] = fv; m_fa[i] = fa;
            m_addr[i] = (m_t[i] < total) ? 4'(m_lo[i] + m_t[i] / len)
                                         : 4'(m_lo[i] + m_n[i] - 1);
            m_act[i] = 1'b0;
          end else begin
            m_t[i] = m_t[i] + 1;
          end
        end
      end
    end
  end

  logic [3:0] c_ea, c_efa;
  bit         c_eb, c_ed, c_efv;
  int         c_ee;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      expect_now(i, c_ea, c_eb, c_ed, c_ee, c_efv, c_efa);
      checks++;
      if (mem_addr_o[i] != c_ea || busy_o[i] != c_eb || done_o[i] != c_ed ||
          int'(err_o[i]) != c_ee || fv_o[i] != c_efv ||
          (c_efv && fa_o[i] != c_efa)) begin
        failures++;
        $display("FAIL model_cmp d%0d t=%0t: addr %0d/%0d busy %b/%b done %b/%b err %0d/%0d fv %b/%b fa %0d/%0d (got/exp)",
                 i, $time, mem_addr_o[i], c_ea, busy_o[i], c_eb, done_o[i], c_ed,
                 err_o[i], c_ee, fv_o[i], c_efv, fa_o[i], c_efa);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [3:0] seen [20];
  int         nseen;

  // Called #1 after a rising edge. Returns the cycle offset of the done pulse
  // relative to the edge that accepted start.
  task automatic run_scan(input int i, input int lo, input int hi,
                          input int collide, output int cyc);
    bit found = 1'b0;
    lo_addr  = 4'(lo);
    hi_addr  = 4'(hi);
    start[i] = 1'b1;
    nseen    = 0;
    @(posedge clk); #1;
    start[i] = 1'b0;
    cyc = 0;
    while (cyc < 200 && !found) begin
      @(negedge clk);
      if (cyc % (lat[i] + 1) == 0 && nseen < 20) begin
        seen[nseen] = mem_addr_o[i];
        nseen++;
      end
      if (done_o[i]) begin
        found = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        start[i] = (cyc == collide);
      end
    end
    start[i] = 1'b0;
    chk("scan_timeout", int'(found), 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_addr"},  int'(mem_addr_o[i]), 0);
    chk({tag, "_busy"},  int'(busy_o[i]), 0);
    chk({tag, "_done"},  int'(done_o[i]), 0);
    chk({tag, "_err"},   int'(err_o[i]), 0);
    chk({tag, "_fv"},    int'(fv_o[i]), 0);
    chk({tag, "_fa"},    int'(fa_o[i]), 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 3; i++) mask[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_zero(i, "reset_state");
    reset = 1'b0;
    @(posedge clk); #1;

    // clean full scan
    run_scan(0, 0, 15, -1, cyc);
    chk("clean_done_cyc", cyc, 32);
    chk("clean_err", int'(err_o[0]), 0);
    chk("clean_fv", int'(fv_o[0]), 0);
    chk("clean_seen0", int'(seen[0]), 0);
    chk("clean_seen7", int'(seen[7]), 7);
    chk("clean_seen15", int'(seen[15]), 15);

    // injected errors at 5 and 9
    mask[0] = 16'h0220;
    run_scan(0, 0, 15, -1, cyc);
    chk("inj_done_cyc", cyc, 32);
    chk("inj_err", int'(err_o[0]), 2);
    chk("inj_fv", int'(fv_o[0]), 1);
    chk("inj_fa", int'(fa_o[0]), 5);

    // wrap range, RD_LAT=2
    run_scan(1, 14, 1, -1, cyc);
    chk("wrap_done_cyc", cyc, 12);
    chk("wrap_seen0", int'(seen[0]), 14);
    chk("wrap_seen1", int'(seen[1]), 15);
    chk("wrap_seen2", int'(seen[2]), 0);
    chk("wrap_seen3", int'(seen[3]), 1);

    // single-word range
    run_scan(0, 6, 6, -1, cyc);
    chk("single_done_cyc", cyc, 2);

    // abort in CHECK of address 3, mismatch at 2
    mask[0]  = 16'h0004;
    lo_addr  = 4'd0;
    hi_addr  = 4'd15;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    abort = 1'b1;
    chk("abort_addr_at", int'(mem_addr_o[0]), 3);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy_o[0]), 0);
    chk("abort_err", int'(err_o[0]), 1);
    chk("abort_fa", int'(fa_o[0]), 2);
    chk("abort_hold_addr", int'(mem_addr_o[0]), 3);
    repeat (4) @(posedge clk);
    #1;
    run_scan(0, 0, 15, -1, cyc);
    chk("post_abort_cyc", cyc, 32);
    chk("post_abort_err", int'(err_o[0]), 1);

    // saturation with mid-scan start collision
    mask[2] = 16'hFFFF;
    run_scan(2, 0, 15, 9, cyc);
    chk("sat_done_cyc", cyc, 32);
    chk("sat_err", int'(err_o[2]), 3);
    chk("sat_fa", int'(fa_o[2]), 0);
    chk("sat_seen5", int'(seen[5]), 5);
    chk("sat_seen10", int'(seen[10]), 10);

    // reset mid-scan at address 7
    mask[0]  = 16'h0020;
    lo_addr  = 4'd0;
    hi_addr  = 4'd15;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("rst_pre_addr", int'(mem_addr_o[0]), 7);
    #1 reset = 1'b1;
    #1 chk_zero(0, "rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_scan(0, 4, 6, -1, cyc);
    chk("rst_rescan_cyc", cyc, 6);
    chk("rst_rescan_seen0", int'(seen[0]), 4);
    chk("rst_rescan_err", int'(err_o[0]), 1);
    chk("rst_rescan_fa", int'(fa_o[0]), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_scan_ctrl.md
# parity_scan_ctrl

Sequencer for the two-bank parity-protected fetch path. On a start request it walks a programmable 4-bit address range across the two banks (addr[3] selects the bank), waits the configured read latency, and checks each word's stored parity bit against its data. It then reports a saturating error count and the address of the first failing word. It replaces free-running ripple-counter addressing with a start/busy/done-controlled scan that the top-level test logic can trigger and abort.

## Interface
- RD_LAT, 1: cycles from a mem_addr update to the sampling of mem_data/mem_parity; legal range 1–7.
- ERR_CNT_W, 5: width of err_count.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- start  in  1  scan request; sampled only in IDLE.
- abort  in  1  terminate the scan; sampled in every non-IDLE state.
- lo_addr  in  4  first address of the range; latched on an accepted start.
- hi_addr  in  4  last address of the range; latched on an accepted start.
- mem_addr  out  4  registered address to the fetch path; bit 3 selects the bank.
- mem_data  in  8  fetched data byte.
- mem_parity  in  1  stored parity bit of the fetched word.
- busy  out  1  high from the accepted start until the cycle DONE or abort is entered.
- done  out  1  one-cycle pulse when the scan completes normally.
- err_count  out  ERR_CNT_W  number of mismatches in the current or last scan; saturates.
- first_err_valid  out  1  set once a mismatch has been captured.
- first_err_addr  out  4  address of the first mismatch; valid only when first_err_valid=1.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- IDLE behaviour:
  - busy=0.
  - If start=1 and abort=0: latch lo/hi, set mem_addr<=lo_addr, clear err_count and first_err_valid, load wait_cnt<=RD_LAT-1, go to WAIT.
  - If start=1 and abort=1 in the same cycle, abort wins and start is ignored.
- WAIT: if wait_cnt==0, go to CHECK; otherwise decrement wait_cnt.
- CHECK:
  - Match rule: the word matches when mem_data[0]==mem_parity; otherwise it is a mismatch.
  - On a mismatch: err_count<=err_count+1, saturating at 2^ERR_CNT_W-1. If first_err_valid=0, capture first_err_addr<=mem_addr and set first_err_valid.
  - If mem_addr==hi_latched, go to DONE.
  - Otherwise set mem_addr<=mem_addr+1 (mod 16), reload wait_cnt, and go to WAIT.
- Wrap-around: when lo>hi the scan wraps through 15→0. When lo==hi exactly one word is checked. The full 16-word scan is lo=0, hi=15.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- Status registers (err_count, first_err_*) hold their values in IDLE until the next accepted start.
- start while busy is ignored; it is neither queued nor restarted.
- abort in WAIT, CHECK or DONE: go to IDLE on the next edge.
  - No done pulse is produced; a pending DONE pulse is suppressed if abort is high in that cycle.
  - err_count and first_err_* keep their values, including any update made by a CHECK in the same cycle.
  - mem_addr holds its value.
- Reset (at any time, including mid-scan): state=IDLE, mem_addr=0, busy=0, done=0, err_count=0, first_err_valid=0, first_err_addr=0.

## Timing
- Accepted start at edge E0: busy=1 and mem_addr=lo from E0.
- Each address occupies RD_LAT+1 cycles: RD_LAT cycles in WAIT, then 1 cycle in CHECK.
- For an N-word range, done is high in the cycle starting at edge E0+N·(RD_LAT+1); busy falls at the same edge.
- With RD_LAT=1, a full 16-word scan has done high 32 cycles after E0.
- mem_data/mem_parity are sampled at the end of the CHECK cycle. The fetch path must therefore be valid RD_LAT cycles after mem_addr changes (it is combinational in the current design).
- The earliest next start is the cycle after DONE, i.e. IDLE.

## Test plan
- Clean memory, full scan: RD_LAT=1, lo=0, hi=15, start pulse → mem_addr steps 0..15 every 2 cycles, done pulse 32 cycles after start, err_count=0, first_err_valid=0.
- Injected errors: bench inverts mem_parity at addresses 5 and 9 → err_count=2, first_err_valid=1, first_err_addr=5 at done.
- Wrap range: lo=14, hi=1, RD_LAT=2 → addresses visited 14,15,0,1 in order, done 12 cycles after start.
- Abort: abort raised during CHECK of address 3, with a mismatch injected at address 2 → busy=0 next cycle, no done pulse, err_count=1, first_err_addr=2; a following start runs a normal scan.
- Saturation and start collision: ERR_CNT_W=2, every word mismatching → err_count stays at 3. A start raised mid-scan has no effect on mem_addr sequencing.
- Reset mid-scan at address 7 → all outputs immediately 0 (before the next clk edge), state IDLE; start after reset release scans from lo correctly.
